// File: rtl/alu_cmd_seq.sv
// rtl/alu_cmd_seq.sv - command sequencer feeding a 4-bit ALU from a small register file
module alu_cmd_seq #(
  parameter int NREG = 4,
  parameter int W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [$clog2(NREG)-1:0] cmd_rd,
  input  logic [$clog2(NREG)-1:0] cmd_rs1,
  input  logic [$clog2(NREG)-1:0] cmd_rs2,
  input  logic                    cmd_imm_en,
  input  logic [W-1:0]            cmd_imm,
  output logic [W-1:0]            alu_a,
  output logic [W-1:0]            alu_b,
  output logic [2:0]              alu_ch,
  input  logic [W-1:0]            alu_f,
  input  logic                    zero_f,
  input  logic                    over_f,
  input  logic                    cout_f,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [W-1:0]            res_data,
  output logic [$clog2(NREG)-1:0] res_rd,
  output logic                    res_z,
  output logic                    res_o,
  output logic                    res_c
);

  localparam int IW = $clog2(NREG);
  localparam logic [2:0] OP_MOVE = 3'b010;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state;
  state_t         next_state;
  logic [W-1:0]   regs [NREG];
  logic [IW-1:0]  rd_q;
  logic           cmd_fire;
  logic           is_move;
  logic [W-1:0]   wb_data;
  logic           wb_z;
  logic           wb_o;
  logic           wb_c;

  assign cmd_ready = (state == IDLE) && rst_n;
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_valid) next_state = EXEC;
      EXEC:    next_state = DONE;
      DONE:    if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Move bypasses the ALU result and flags; only the zero-detect is local.
  always_comb begin
    is_move = (alu_ch == OP_MOVE);
    wb_data = alu_f;
    wb_z    = zero_f;
    wb_o    = over_f;
    wb_c    = cout_f;
    if (is_move) begin
      wb_data = alu_b;
      wb_z    = (alu_b == '0);
      wb_o    = 1'b0;
      wb_c    = 1'b0;
    end
  end

  // The ALU input registers double as the latched operands, so they
  // naturally hold their last value outside EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ch    <= '0;
      rd_q      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      res_z     <= 1'b0;
      res_o     <= 1'b0;
      res_c     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            alu_a  <= regs[cmd_rs1];
            alu_b  <= cmd_imm_en ? cmd_imm : regs[cmd_rs2];
            alu_ch <= cmd_op;
            rd_q   <= cmd_rd;
          end
        end
        EXEC: begin
          regs[rd_q] <= wb_data;
          res_valid  <= 1'b1;
          res_data   <= wb_data;
          res_rd     <= rd_q;
          res_z      <= wb_z;
          res_o      <= wb_o;
          res_c      <= wb_c;
        end
        DONE: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
